// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, tracks the single in-flight read of a
// one-cycle-latency memory and buffers returned words in a 2-entry FIFO towards decode.
// Optional misaligned-redirect trap: define IMEM_FETCH_MISALIGN_TRAP_EN.
module imem_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fetch_fault
);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fetch_pc_q, inflight_pc_q, pc0_q, pc1_q;
    logic [31:0]       instr0_q, instr1_q;
    logic [1:0]        count_q;
    logic              inflight_q;

    logic              pop, push, issue;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] redir_pc;

    assign pop  = out_valid & out_ready;
    assign push = inflight_q & ~redirect_valid;
    // Entries that will be held after this cycle; issuing keeps room for the new word.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == StRun) & fetch_en & ~redirect_valid & (occupancy <= 3'd1);

`ifdef IMEM_FETCH_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign    = |redirect_pc[1:0];
    assign redir_pc    = redirect_pc;
    assign fetch_fault = (state_q == StFault);
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redir_pc            = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign fetch_fault         = 1'b0;
`endif

    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = pc0_q;
    assign out_instr = instr0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
            pc0_q         <= '0;
            pc1_q         <= '0;
            instr0_q      <= '0;
            instr1_q      <= '0;
        end else if (redirect_valid) begin
            // A head pop in this cycle is simply not re-presented after the flush.
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            fetch_pc_q <= redir_pc;
`ifdef IMEM_FETCH_MISALIGN_TRAP_EN
            state_q    <= misalign ? StFault : StRun;
`endif
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_q    <= inflight_pc_q;
                        instr0_q <= mem_rdata;
                    end else begin
                        pc1_q    <= inflight_pc_q;
                        instr1_q <= mem_rdata;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    pc0_q    <= pc1_q;
                    instr0_q <= instr1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        pc0_q    <= inflight_pc_q;
                        instr0_q <= mem_rdata;
                    end else begin
                        pc0_q    <= pc1_q;
                        instr0_q <= instr1_q;
                        pc1_q    <= inflight_pc_q;
                        instr1_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: streaming, stall, redirect, fetch_en gating, PC wrap,
// misaligned redirect (both builds) and mid-operation reset.
module tb_imem_fetch_ctrl;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_en = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              fetch_fault;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_pc = '0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // One-cycle-latency memory: word i = A000_0000 + i.
    always @(posedge clk) mem_rdata <= word_at(mem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream checker: every valid head must be the next expected PC, held until accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else begin
            if (out_valid) begin
                check_eq("mon_pc", out_pc, exp_pc);
                check_eq("mon_instr", out_instr, word_at(exp_pc));
                if (out_ready) exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        end
    end

    initial begin
        #2;
        check_eq("rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_fault", {31'b0, fetch_fault}, 32'h0);
        check_eq("rst_addr", mem_addr, 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("k1_valid", {31'b0, out_valid}, 32'h0);
        check_eq("k1_addr", mem_addr, 32'h4);
        tick();
        check_eq("k2_valid", {31'b0, out_valid}, 32'h1);
        check_eq("k2_pc", out_pc, 32'h0);
        check_eq("k2_instr", out_instr, 32'hA000_0000);
        check_eq("k2_addr", mem_addr, 32'h8);
        tick();
        check_eq("k3_pc", out_pc, 32'h4);
        check_eq("k3_instr", out_instr, 32'hA000_0001);
        repeat (5) tick();
        check_eq("k8_addr", mem_addr, 32'h20);
        check_eq("k8_pc", out_pc, 32'h18);

        out_ready = 1'b0;
        tick();
        check_eq("stall_addr0", mem_addr, 32'h20);
        check_eq("stall_pc0", out_pc, 32'h18);
        repeat (4) tick();
        check_eq("stall_addr4", mem_addr, 32'h20);
        check_eq("stall_pc4", out_pc, 32'h18);
        check_eq("stall_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        tick();
        check_eq("resume_pc", out_pc, 32'h1C);
        check_eq("resume_addr", mem_addr, 32'h24);
        repeat (2) tick();
        check_eq("pre_redir_addr", mem_addr, 32'h2C);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_addr", mem_addr, 32'h40);
        check_eq("redir_flush", {31'b0, out_valid}, 32'h0);
        tick();
        check_eq("redir_addr2", mem_addr, 32'h44);
        check_eq("redir_valid2", {31'b0, out_valid}, 32'h0);
        tick();
        check_eq("redir_valid3", {31'b0, out_valid}, 32'h1);
        check_eq("redir_pc3", out_pc, 32'h40);
        check_eq("redir_instr3", out_instr, 32'hA000_0010);
        tick();
        check_eq("redir_pc4", out_pc, 32'h44);
        check_eq("redir_addr4", mem_addr, 32'h4C);

        fetch_en = 1'b0;
        tick();
        check_eq("fen_last_pc", out_pc, 32'h48);
        check_eq("fen_last_valid", {31'b0, out_valid}, 32'h1);
        tick();
        check_eq("fen_drained", {31'b0, out_valid}, 32'h0);
        check_eq("fen_addr", mem_addr, 32'h4C);
        tick();
        check_eq("fen_addr2", mem_addr, 32'h4C);
        fetch_en = 1'b1;
        tick();
        check_eq("fen_resume_addr", mem_addr, 32'h50);
        tick();
        check_eq("fen_resume_pc", out_pc, 32'h4C);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_eq("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr1", mem_addr, 32'h0);
        tick();
        check_eq("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr0", out_instr, 32'hDFFF_FFFF);
        tick();
        check_eq("wrap_pc1", out_pc, 32'h0);
        check_eq("wrap_instr1", out_instr, 32'hA000_0000);
        tick();
        check_eq("wrap_pc2", out_pc, 32'h4);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check_eq("mis_valid", {31'b0, out_valid}, 32'h0);
`ifdef IMEM_FETCH_MISALIGN_TRAP_EN
        check_eq("mis_fault", {31'b0, fetch_fault}, 32'h1);
        check_eq("mis_addr", mem_addr, 32'h42);
        tick();
        check_eq("mis_addr2", mem_addr, 32'h42);
        check_eq("mis_fault2", {31'b0, fetch_fault}, 32'h1);
        tick();
        check_eq("mis_valid3", {31'b0, out_valid}, 32'h0);
`else
        check_eq("mis_fault", {31'b0, fetch_fault}, 32'h0);
        check_eq("mis_addr", mem_addr, 32'h40);
        tick();
        check_eq("mis_addr2", mem_addr, 32'h44);
        tick();
        check_eq("mis_valid3", {31'b0, out_valid}, 32'h1);
        check_eq("mis_pc3", out_pc, 32'h40);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check_eq("rec_fault", {31'b0, fetch_fault}, 32'h0);
        check_eq("rec_addr", mem_addr, 32'h80);
        tick();
        check_eq("rec_valid1", {31'b0, out_valid}, 32'h0);
        tick();
        check_eq("rec_valid2", {31'b0, out_valid}, 32'h1);
        check_eq("rec_pc2", out_pc, 32'h80);
        tick();
        check_eq("rec_pc3", out_pc, 32'h84);

        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("mrst_addr", mem_addr, 32'h0);
        check_eq("mrst_pc", out_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mrst_k1_valid", {31'b0, out_valid}, 32'h0);
        tick();
        check_eq("mrst_k2_pc", out_pc, 32'h0);
        check_eq("mrst_k2_valid", {31'b0, out_valid}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
